fire_sample_ctrl: RTL and testbench

//  Sequencer in front of the EMA fire detector. Paces lux reads from the light-sensor reader

---
 rtl/fire_sample_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_fire_sample_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fire_sample_ctrl.sv
// Sample sequencer for the EMA fire detector: paces sensor reads, strobes samples and confirms fire.
// Optional read timeout / sensor_fault logic is built only when FIRE_CTRL_TIMEOUT_EN is defined.
module fire_sample_ctrl #(
    parameter int SAMPLE_PERIOD  = 50000,
    parameter int CONFIRM_COUNT  = 3,
    parameter int WARMUP_SAMPLES = 8,
    parameter int RD_TIMEOUT     = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic        rd_req,
    input  logic        rd_ack,
    input  logic [15:0] rd_data,
    output logic [15:0] lux_out,
    output logic        lux_valid,
    input  logic        fire_in,
    input  logic        alarm_clr,
    output logic        fire_alarm,
    output logic        busy,
    output logic        overrun,
    output logic        sensor_fault
);

    localparam int PW = $clog2(SAMPLE_PERIOD + 1);
    localparam int CW = $clog2(CONFIRM_COUNT + 1);
    localparam int WW = (WARMUP_SAMPLES > 0) ? $clog2(WARMUP_SAMPLES + 1) : 1;

    localparam logic [PW-1:0] PERIOD_LAST = PW'(SAMPLE_PERIOD - 1);
    localparam logic [CW-1:0] CONF_MAX    = CW'(CONFIRM_COUNT);
    localparam logic [WW-1:0] WARM_INIT   = WW'(WARMUP_SAMPLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        VALID = 2'd2,
        EVAL  = 2'd3
    } state_t;

    state_t        state_reg, state_next;
    logic [PW-1:0] period_reg, period_next;
    logic          pending_reg, pending_next;
    logic          overrun_reg, overrun_next;
    logic [WW-1:0] warm_reg, warm_next;
    logic [CW-1:0] conf_reg, conf_next;
    logic          alarm_reg, alarm_next;
    logic [15:0]   lux_reg, lux_next;

    logic tick;
    logic take;
    logic eval_now;
    logic timeout_expired;

    assign tick     = enable && (period_reg == PERIOD_LAST);
    assign take     = (state_reg == IDLE) && pending_reg;
    assign eval_now = (state_reg == EVAL);

    // Period counter and pending/overrun bookkeeping
    always_comb begin
        period_next  = period_reg;
        pending_next = pending_reg;
        overrun_next = overrun_reg;
        if (!enable || tick) begin
            period_next = '0;
        end else begin
            period_next = period_reg + 1'b1;
        end
        if (take) begin
            pending_next = 1'b0;
        end else if (tick) begin
            pending_next = 1'b1;
        end
        if (tick && pending_reg) begin
            overrun_next = 1'b1;
        end
        if (alarm_clr) begin
            overrun_next = 1'b0;
        end
    end

    always_comb begin
        state_next = state_reg;
        lux_next   = lux_reg;
        case (state_reg)
            IDLE: begin
                if (pending_reg) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (rd_ack) begin
                    lux_next   = rd_data;
                    state_next = VALID;
                end else if (timeout_expired) begin
                    state_next = IDLE;
                end
            end
            VALID:   state_next = EVAL;
            EVAL:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Warm-up evaluations are swallowed; afterwards a positive streak confirms the alarm
    always_comb begin
        warm_next  = warm_reg;
        conf_next  = conf_reg;
        alarm_next = alarm_reg;
        if (eval_now) begin
            if (warm_reg != '0) begin
                warm_next = warm_reg - 1'b1;
            end else if (fire_in) begin
                conf_next  = (conf_reg == CONF_MAX) ? CONF_MAX : conf_reg + 1'b1;
                alarm_next = alarm_reg | (conf_next == CONF_MAX);
            end else begin
                conf_next = '0;
            end
        end
        if (alarm_clr) begin
            conf_next  = '0;
            alarm_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            period_reg  <= '0;
            pending_reg <= 1'b0;
            overrun_reg <= 1'b0;
            warm_reg    <= WARM_INIT;
            conf_reg    <= '0;
            alarm_reg   <= 1'b0;
            lux_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            period_reg  <= period_next;
            pending_reg <= pending_next;
            overrun_reg <= overrun_next;
            warm_reg    <= warm_next;
            conf_reg    <= conf_next;
            alarm_reg   <= alarm_next;
            lux_reg     <= lux_next;
        end
    end

`ifdef FIRE_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(RD_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(RD_TIMEOUT - 1);

    logic [TW-1:0] to_reg, to_next;
    logic          fault_reg, fault_next;

    // An ack arriving on the expiry cycle still completes the read
    assign timeout_expired = (state_reg == REQ) && !rd_ack && (to_reg == TO_LAST);

    always_comb begin
        to_next    = (state_reg == REQ) ? to_reg + 1'b1 : '0;
        fault_next = fault_reg;
        if (timeout_expired) begin
            fault_next = 1'b1;
        end
        if (alarm_clr) begin
            fault_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_reg    <= '0;
            fault_reg <= 1'b0;
        end else begin
            to_reg    <= to_next;
            fault_reg <= fault_next;
        end
    end

    assign sensor_fault = fault_reg;
`else
    logic unused_rd_timeout;
    assign unused_rd_timeout = (RD_TIMEOUT > 0);
    assign timeout_expired   = 1'b0;
    assign sensor_fault      = 1'b0;
`endif

    assign rd_req     = (state_reg == REQ);
    assign lux_valid  = (state_reg == VALID);
    assign busy       = (state_reg != IDLE);
    assign lux_out    = lux_reg;
    assign fire_alarm = alarm_reg;
    assign overrun    = overrun_reg;

endmodule

// File: tb/tb_fire_sample_ctrl.sv
// Bench for fire_sample_ctrl: vector table for the confirm/warm-up/clear rules, random samples
// against a streak-counting reference model, plus hand sequences for overrun/timeout/reset.
module tb_fire_sample_ctrl;

    localparam int SP  = 10;
    localparam int CC  = 3;
    localparam int WS  = 2;
    localparam int RTO = 5;
`ifdef FIRE_CTRL_TIMEOUT_EN
    localparam int MAXD = RTO - 1;
`else
    localparam int MAXD = 5;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        rd_req;
    logic        rd_ack = 1'b0;
    logic [15:0] rd_data = 16'h0;
    logic [15:0] lux_out;
    logic        lux_valid;
    logic        fire_in = 1'b0;
    logic        alarm_clr = 1'b0;
    logic        fire_alarm;
    logic        busy;
    logic        overrun;
    logic        sensor_fault;

    always #5 clk = ~clk;

    fire_sample_ctrl #(
        .SAMPLE_PERIOD (SP),
        .CONFIRM_COUNT (CC),
        .WARMUP_SAMPLES(WS),
        .RD_TIMEOUT    (RTO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .rd_req      (rd_req),
        .rd_ack      (rd_ack),
        .rd_data     (rd_data),
        .lux_out     (lux_out),
        .lux_valid   (lux_valid),
        .fire_in     (fire_in),
        .alarm_clr   (alarm_clr),
        .fire_alarm  (fire_alarm),
        .busy        (busy),
        .overrun     (overrun),
        .sensor_fault(sensor_fault)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_req = 0;
    int txn = 0;
    int lux_cnt = 0;
    int ack_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (lux_valid) lux_cnt <= lux_cnt + 1;
        if (rd_ack && rd_req) ack_cnt <= ack_cnt + 1;
    end

    // Reference model: evaluation index, current positive streak, latched alarm
    int m_idx = 0;
    int m_streak = 0;
    bit m_alarm = 1'b0;

    task automatic model_reset();
        m_idx = 0; m_streak = 0; m_alarm = 1'b0;
    endtask

    task automatic model_clr();
        m_streak = 0; m_alarm = 1'b0;
    endtask

    task automatic model_eval(input bit fire, input bit clr);
        if (m_idx >= WS) begin
            m_streak = fire ? m_streak + 1 : 0;
            if (m_streak >= CC) m_alarm = 1'b1;
        end
        m_idx++;
        if (clr) model_clr();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic pulse_clr();
        alarm_clr = 1'b1;
        @(posedge clk); #1;
        alarm_clr = 1'b0;
        model_clr();
    endtask

    task automatic wait_req(output bit ok);
        int n;
        n = 0;
        while (rd_req !== 1'b1 && n < 4 * SP) begin
            @(posedge clk); #1;
            n++;
        end
        ok = (rd_req === 1'b1);
        check("req_wait", {31'd0, rd_req}, 32'd1);
    endtask

    // One full sample transaction; returns fire_alarm as seen one cycle after EVAL
    task automatic do_sample(input int d, input logic [15:0] data, input bit fire,
                             input bit clr, input bit chk_period, output bit alarm_seen);
        bit ok;
        wait_req(ok);
        alarm_seen = fire_alarm;
        if (!ok) return;
        if (chk_period) check("req_period", cyc - last_req, SP);
        last_req = cyc;
        check("valid_in_req", {31'd0, lux_valid}, 32'd0);
        for (int i = 0; i < d; i++) begin
            @(posedge clk); #1;
            check("req_held", {31'd0, rd_req}, 32'd1);
        end
        rd_ack = 1'b1;
        rd_data = data;
        @(posedge clk); #1;
        check("lux_valid", {31'd0, lux_valid}, 32'd1);
        check("lux_out", {16'd0, lux_out}, {16'd0, data});
        check("req_drop", {31'd0, rd_req}, 32'd0);
        rd_ack = 1'b1;                       // stray ack outside REQ must be ignored
        rd_data = ~data;
        fire_in = fire;
        @(posedge clk); #1;
        rd_ack = 1'b0;
        rd_data = 16'($urandom);
        check("valid_one_cycle", {31'd0, lux_valid}, 32'd0);
        check("lux_hold", {16'd0, lux_out}, {16'd0, data});
        check("busy_eval", {31'd0, busy}, 32'd1);
        alarm_clr = clr;
        @(posedge clk); #1;
        alarm_clr = 1'b0;
        fire_in = 1'b0;
        model_eval(fire, clr);
        check("busy_idle", {31'd0, busy}, 32'd0);
        alarm_seen = fire_alarm;
        txn++;
        $display("txn %0d: d=%0d data=%h fire=%0b clr=%0b -> fire_alarm=%0b overrun=%0b",
                 txn, d, data, fire, clr, fire_alarm, overrun);
    endtask

    typedef struct {
        int          d;
        logic [15:0] data;
        bit          fire;
        bit          clr;
        bit          per;
        bit          exp_alarm;
    } vec_t;

    vec_t tbl[21];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit a;
        bit ok;
        int seen;
        int cnt;
        int lux_before;

        // warm-up, confirm, broken streak, sticky alarm, clear-beats-set
        tbl[0]  = '{2, 16'h0123, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{2, 16'h0123, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{2, 16'h0123, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{2, 16'h0123, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{2, 16'h0123, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[5]  = '{0, 16'hA5A5, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{3, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{4, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{0, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1, 16'h5678, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{4, 16'h9ABC, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{2, 16'hDEF0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[13] = '{3, 16'h0F0F, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[14] = '{0, 16'hF0F0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[15] = '{1, 16'h3C3C, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[16] = '{2, 16'hC3C3, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[17] = '{3, 16'h7777, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[18] = '{4, 16'h8888, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[19] = '{0, 16'h4242, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[20] = '{1, 16'h2424, 1'b0, 1'b1, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("rst_rd_req", {31'd0, rd_req}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_lux_valid", {31'd0, lux_valid}, 32'd0);
        check("rst_lux_out", {16'd0, lux_out}, 32'd0);
        check("rst_alarm", {31'd0, fire_alarm}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_fault", {31'd0, sensor_fault}, 32'd0);
        rst_n = 1'b1;
        model_reset();

        // enable low: no ticks, no requests
        seen = 0;
        for (int i = 0; i < 3 * SP; i++) begin
            @(posedge clk); #1;
            if (rd_req || busy) seen++;
        end
        check("disabled_no_req", seen, 0);
        enable = 1'b1;

        for (int i = 0; i < 21; i++) begin
            do_sample(tbl[i].d, tbl[i].data, tbl[i].fire, tbl[i].clr, tbl[i].per, a);
            check($sformatf("tbl%0d_alarm", i), {31'd0, a}, {31'd0, tbl[i].exp_alarm});
        end

        for (int i = 0; i < 40; i++) begin
            int d;
            bit f, c;
            d = int'($urandom_range(MAXD, 0));
            f = ($urandom_range(3, 0) != 0);
            c = ($urandom_range(7, 0) == 0);
            do_sample(d, 16'($urandom), f, c, 1'b0, a);
            check($sformatf("rnd%0d_alarm", i), {31'd0, a}, {31'd0, m_alarm});
        end
        check("no_overrun_yet", {31'd0, overrun}, 32'd0);

`ifndef FIRE_CTRL_TIMEOUT_EN
        // long ack stall: the second tick during the stall is dropped
        do_sample(24, 16'hCAFE, 1'b0, 1'b0, 1'b0, a);
        check("stall_alarm", {31'd0, a}, {31'd0, m_alarm});
        check("overrun_set", {31'd0, overrun}, 32'd1);
        pulse_clr();
        check("overrun_clr", {31'd0, overrun}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            do_sample(2, 16'h1000 + 16'(i), 1'b1, 1'b0, 1'b0, a);
            check("post_stall_alarm", {31'd0, a}, {31'd0, m_alarm});
        end
        check("overrun_stays_clr", {31'd0, overrun}, 32'd0);
`else
        // no ack at all: request abandoned after RTO cycles, fault latched
        lux_before = lux_cnt;
        wait_req(ok);
        cnt = 0;
        if (ok) begin
            cnt = 1;
            for (int i = 0; i < 4 * RTO; i++) begin
                @(posedge clk); #1;
                if (rd_req) cnt++;
                else break;
            end
        end
        check("timeout_req_cycles", cnt, RTO);
        check("timeout_fault", {31'd0, sensor_fault}, 32'd1);
        check("timeout_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        check("timeout_no_valid", lux_cnt, lux_before);
        check("timeout_alarm", {31'd0, fire_alarm}, {31'd0, m_alarm});
        pulse_clr();
        check("fault_clr", {31'd0, sensor_fault}, 32'd0);
`endif

        // reset in the middle of a request
        wait_req(ok);
        rst_n = 1'b0;
        #1;
        check("midrst_req", {31'd0, rd_req}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_alarm", {31'd0, fire_alarm}, 32'd0);
        check("midrst_lux", {16'd0, lux_out}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            do_sample(1, 16'hBEE0 + 16'(i), 1'b1, 1'b0, 1'b0, a);
            check($sformatf("postrst%0d_alarm", i), {31'd0, a}, {31'd0, m_alarm});
        end
        check("final_alarm", {31'd0, fire_alarm}, 32'd1);
        @(posedge clk); #1;
        check("valid_per_ack", lux_cnt, ack_cnt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
